// File: rtl/rs_age_queue.sv
// Age-ordered reservation station: buffers decoded ops, wakes operands off the CDB, dispatches oldest ready op.
// Optional RS_BYPASS_EN: an incoming op that is ready dispatches directly when no resident entry is ready.
module rs_age_queue #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = 5,
  parameter int OP_W     = 6,
  parameter int XLEN     = 32,
  parameter int FREE_MIN = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear,
  output logic                       rs_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_overflow,
  input  logic                       in_valid,
  input  logic [TAG_W-1:0]           in_rob,
  input  logic [OP_W-1:0]            in_op,
  input  logic                       in_p1,
  input  logic                       in_p2,
  input  logic [TAG_W-1:0]           in_q1,
  input  logic [TAG_W-1:0]           in_q2,
  input  logic [XLEN-1:0]            in_v1,
  input  logic [XLEN-1:0]            in_v2,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_val,
  output logic                       calc_en,
  output logic [OP_W-1:0]            calc_op,
  output logic [XLEN-1:0]            calc_v1,
  output logic [XLEN-1:0]            calc_v2,
  output logic [TAG_W-1:0]           calc_rob
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]             valid_q, valid_d, p1_q, p1_d, p2_q, p2_d;
  logic [DEPTH-1:0][OP_W-1:0]   op_q, op_d;
  logic [DEPTH-1:0][TAG_W-1:0]  rob_q, rob_d, q1_q, q1_d, q2_q, q2_d;
  logic [DEPTH-1:0][XLEN-1:0]   v1_q, v1_d, v2_q, v2_d;
  // older_q[i][j] = 1 when entry j was accepted before entry i
  logic [DEPTH-1:0][DEPTH-1:0]  older_q, older_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         err_q, err_d;
  logic                         calc_en_q, calc_en_d;
  logic [OP_W-1:0]              calc_op_q, calc_op_d;
  logic [XLEN-1:0]              calc_v1_q, calc_v1_d, calc_v2_q, calc_v2_d;
  logic [TAG_W-1:0]             calc_rob_q, calc_rob_d;

  logic [DEPTH-1:0] ready;
  logic             free_any, sel_any, byp, do_alloc;
  logic [IW-1:0]    alloc_idx, sel_idx;
  logic             hit1, hit2, in_p1_c, in_p2_c;
  logic [XLEN-1:0]  in_v1_c, in_v2_c;

  assign hit1    = cdb_valid && in_p1 && (in_q1 == cdb_tag);
  assign hit2    = cdb_valid && in_p2 && (in_q2 == cdb_tag);
  assign in_p1_c = in_p1 && !hit1;
  assign in_p2_c = in_p2 && !hit2;
  assign in_v1_c = hit1 ? cdb_val : in_v1;
  assign in_v2_c = hit2 ? cdb_val : in_v2;

  always_comb begin
    ready     = valid_q & ~p1_q & ~p2_q;
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any  = 1'b1;
        alloc_idx = IW'(i);
      end
    end
    // the oldest ready entry is the one with no ready entry older than itself
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && ((ready & older_q[i]) == '0)) begin
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

`ifdef RS_BYPASS_EN
  assign byp = in_valid && !in_p1_c && !in_p2_c && !sel_any;
`else
  assign byp = 1'b0;
`endif

  assign do_alloc = in_valid && free_any && !byp;

  always_comb begin
    valid_d    = valid_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    op_d       = op_q;
    rob_d      = rob_q;
    q1_d       = q1_q;
    q2_d       = q2_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    older_d    = older_q;
    count_d    = count_q;
    err_d      = err_q;
    calc_en_d  = calc_en_q;
    calc_op_d  = calc_op_q;
    calc_v1_d  = calc_v1_q;
    calc_v2_d  = calc_v2_q;
    calc_rob_d = calc_rob_q;
    if (rdy_in) begin
      if (clear) begin
        valid_d   = '0;
        count_d   = '0;
        calc_en_d = 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && p1_q[i] && cdb_valid && (q1_q[i] == cdb_tag)) begin
            p1_d[i] = 1'b0;
            v1_d[i] = cdb_val;
          end
          if (valid_q[i] && p2_q[i] && cdb_valid && (q2_q[i] == cdb_tag)) begin
            p2_d[i] = 1'b0;
            v2_d[i] = cdb_val;
          end
        end
        calc_en_d = sel_any || byp;
        if (sel_any) begin
          valid_d[sel_idx] = 1'b0;
          calc_op_d        = op_q[sel_idx];
          calc_v1_d        = v1_q[sel_idx];
          calc_v2_d        = v2_q[sel_idx];
          calc_rob_d       = rob_q[sel_idx];
        end else if (byp) begin
          calc_op_d  = in_op;
          calc_v1_d  = in_v1_c;
          calc_v2_d  = in_v2_c;
          calc_rob_d = in_rob;
        end
        if (do_alloc) begin
          valid_d[alloc_idx] = 1'b1;
          op_d[alloc_idx]    = in_op;
          rob_d[alloc_idx]   = in_rob;
          p1_d[alloc_idx]    = in_p1_c;
          q1_d[alloc_idx]    = in_q1;
          v1_d[alloc_idx]    = in_v1_c;
          p2_d[alloc_idx]    = in_p2_c;
          q2_d[alloc_idx]    = in_q2;
          v2_d[alloc_idx]    = in_v2_c;
          // a reused slot must drop any stale "older than" relations
          for (int i = 0; i < DEPTH; i++) older_d[i][alloc_idx] = 1'b0;
          older_d[alloc_idx] = valid_q;
        end
        if (in_valid && !free_any && !byp) err_d = 1'b1;
        count_d = count_q + CW'(do_alloc) - CW'(sel_any);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q    <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      op_q       <= '0;
      rob_q      <= '0;
      q1_q       <= '0;
      q2_q       <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      older_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      calc_en_q  <= 1'b0;
      calc_op_q  <= '0;
      calc_v1_q  <= '0;
      calc_v2_q  <= '0;
      calc_rob_q <= '0;
    end else begin
      valid_q    <= valid_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      op_q       <= op_d;
      rob_q      <= rob_d;
      q1_q       <= q1_d;
      q2_q       <= q2_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      older_q    <= older_d;
      count_q    <= count_d;
      err_q      <= err_d;
      calc_en_q  <= calc_en_d;
      calc_op_q  <= calc_op_d;
      calc_v1_q  <= calc_v1_d;
      calc_v2_q  <= calc_v2_d;
      calc_rob_q <= calc_rob_d;
    end
  end

  assign rs_full      = (int'(count_q) + FREE_MIN) > DEPTH;
  assign count        = count_q;
  assign err_overflow = err_q;
  assign calc_en      = calc_en_q;
  assign calc_op      = calc_op_q;
  assign calc_v1      = calc_v1_q;
  assign calc_v2      = calc_v2_q;
  assign calc_rob     = calc_rob_q;

endmodule

// File: tb/tb_rs_age_queue.sv
// Bench for rs_age_queue: age-ordered queue model checked every cycle, plus directed literal checks.
module tb_rs_age_queue;
  localparam int DEPTH = 16, TAG_W = 5, OP_W = 6, XLEN = 32, FREE_MIN = 3;
  localparam int CW = $clog2(DEPTH+1);

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in, clear, in_valid, in_p1, in_p2, cdb_valid;
  logic [TAG_W-1:0] in_rob, in_q1, in_q2, cdb_tag;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_v1, in_v2, cdb_val;
  logic rs_full, err_overflow, calc_en;
  logic [CW-1:0] count;
  logic [OP_W-1:0] calc_op;
  logic [XLEN-1:0] calc_v1, calc_v2;
  logic [TAG_W-1:0] calc_rob;

  rs_age_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .XLEN(XLEN), .FREE_MIN(FREE_MIN)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .rs_full(rs_full), .count(count), .err_overflow(err_overflow),
    .in_valid(in_valid), .in_rob(in_rob), .in_op(in_op),
    .in_p1(in_p1), .in_p2(in_p2), .in_q1(in_q1), .in_q2(in_q2),
    .in_v1(in_v1), .in_v2(in_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .calc_en(calc_en), .calc_op(calc_op), .calc_v1(calc_v1), .calc_v2(calc_v2), .calc_rob(calc_rob)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: resident ops kept in a queue in acceptance order
  typedef struct {
    logic [OP_W-1:0] op; logic [TAG_W-1:0] rob;
    logic p1; logic [TAG_W-1:0] q1; logic [XLEN-1:0] v1;
    logic p2; logic [TAG_W-1:0] q2; logic [XLEN-1:0] v2;
  } op_t;
  op_t mq[$];
  logic m_en = 1'b0, m_err = 1'b0;
  logic [OP_W-1:0] m_op = '0;
  logic [XLEN-1:0] m_v1 = '0, m_v2 = '0;
  logic [TAG_W-1:0] m_rob = '0;

  always @(posedge rst_in) begin
    mq.delete();
    m_en = 1'b0; m_err = 1'b0; m_op = '0; m_v1 = '0; m_v2 = '0; m_rob = '0;
  end

  task automatic model_edge();
    int sel;
    bit was_full, byp;
    op_t n;
    sel = -1;
    was_full = (mq.size() == DEPTH);
    if (clear) begin
      mq.delete();
      m_en = 1'b0;
      return;
    end
    foreach (mq[i]) if (sel < 0 && !mq[i].p1 && !mq[i].p2) sel = i;
    foreach (mq[i]) begin
      if (cdb_valid && mq[i].p1 && mq[i].q1 == cdb_tag) begin mq[i].p1 = 0; mq[i].v1 = cdb_val; end
      if (cdb_valid && mq[i].p2 && mq[i].q2 == cdb_tag) begin mq[i].p2 = 0; mq[i].v2 = cdb_val; end
    end
    n.op = in_op; n.rob = in_rob;
    n.q1 = in_q1; n.q2 = in_q2;
    n.p1 = in_p1 && !(cdb_valid && in_q1 == cdb_tag);
    n.p2 = in_p2 && !(cdb_valid && in_q2 == cdb_tag);
    n.v1 = (in_p1 && !n.p1) ? cdb_val : in_v1;
    n.v2 = (in_p2 && !n.p2) ? cdb_val : in_v2;
    byp = 0;
`ifdef RS_BYPASS_EN
    byp = (sel < 0) && in_valid && !n.p1 && !n.p2;
`endif
    if (sel >= 0) begin
      m_en = 1; m_op = mq[sel].op; m_v1 = mq[sel].v1; m_v2 = mq[sel].v2; m_rob = mq[sel].rob;
      mq.delete(sel);
    end else if (byp) begin
      m_en = 1; m_op = n.op; m_v1 = n.v1; m_v2 = n.v2; m_rob = n.rob;
    end else begin
      m_en = 0;
    end
    if (in_valid && !byp) begin
      if (was_full) m_err = 1;
      else mq.push_back(n);
    end
  endtask

  always @(posedge clk_in) begin
    if (!rst_in && rdy_in) model_edge();
    #1;
    if (!rst_in) begin
      chk("m_calc_en", calc_en, m_en);
      chk("m_calc_op", calc_op, m_op);
      chk("m_calc_v1", calc_v1, m_v1);
      chk("m_calc_v2", calc_v2, m_v2);
      chk("m_calc_rob", calc_rob, m_rob);
      chk("m_count", count, mq.size());
      chk("m_rs_full", rs_full, (DEPTH - mq.size()) < FREE_MIN);
      chk("m_err", err_overflow, m_err);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle();
    rdy_in = 1; clear = 0; in_valid = 0; cdb_valid = 0;
    in_p1 = 0; in_p2 = 0; in_q1 = 0; in_q2 = 0; in_v1 = 0; in_v2 = 0;
    in_rob = 0; in_op = 0; cdb_tag = 0; cdb_val = 0;
  endtask

  task automatic put(int rob, int op, bit p1, int q1, int v1, bit p2, int q2, int v2);
    in_valid = 1; in_rob = TAG_W'(rob); in_op = OP_W'(op);
    in_p1 = p1; in_q1 = TAG_W'(q1); in_v1 = XLEN'(v1);
    in_p2 = p2; in_q2 = TAG_W'(q2); in_v2 = XLEN'(v2);
  endtask

  task automatic bcast(int tag, int val);
    cdb_valid = 1; cdb_tag = TAG_W'(tag); cdb_val = XLEN'(val);
  endtask

  initial begin
    idle();
    #2;
    chk("rst_count", count, 0);
    chk("rst_calc_en", calc_en, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_full", rs_full, 0);
    @(negedge clk_in);
    rst_in = 0;
    tick();

    // age order
    put(3, 1, 1, 7, 0, 0, 0, 1); tick();
    put(4, 2, 0, 0, 'h22, 0, 0, 2); tick();
    put(5, 3, 0, 0, 'h33, 0, 0, 3); tick();
    chk("age_first_en", calc_en, 1);
    chk("age_first_rob", calc_rob, 4);
    idle(); bcast(7, 'h11); tick();
    chk("age_second_rob", calc_rob, 5);
    idle(); tick();
    chk("age_third_rob", calc_rob, 3);
    chk("age_third_v1", calc_v1, 'h11);
    tick();
    chk("age_drain_en", calc_en, 0);

    // in-flight capture
    put(6, 2, 1, 9, 0, 0, 0, 3); bcast(9, 'hDEAD); tick();
    idle();
`ifndef RS_BYPASS_EN
    chk("inflight_e0_en", calc_en, 0);
    tick();
`endif
    chk("inflight_en", calc_en, 1);
    chk("inflight_v1", calc_v1, 'hDEAD);
    chk("inflight_rob", calc_rob, 6);
    tick();

    // fill and overflow
    for (int k = 1; k <= 17; k++) begin
      put(k, 4, 1, 20, 0, 0, 0, k); tick();
      if (k == 13) begin chk("full_13_cnt", count, 13); chk("full_13_full", rs_full, 0); end
      if (k == 14) begin chk("full_14_cnt", count, 14); chk("full_14_full", rs_full, 1); end
      if (k == 16) chk("full_16_err", err_overflow, 0);
    end
    chk("ovf_err", err_overflow, 1);
    chk("ovf_count", count, 16);
    idle(); clear = 1; tick();
    chk("clr_count", count, 0);
    chk("clr_err_kept", err_overflow, 1);

    // flush with simultaneous in_valid
    idle();
    for (int k = 0; k < 8; k++) begin put(k, 5, 1, 20, 0, 0, 0, 0); tick(); end
    chk("flush_pre_cnt", count, 8);
    put(9, 5, 0, 0, 1, 0, 0, 1); clear = 1; tick();
    chk("flush_cnt", count, 0);
    chk("flush_en", calc_en, 0);
    chk("flush_full", rs_full, 0);
    idle();
    for (int k = 0; k < 3; k++) begin tick(); chk("flush_quiet_en", calc_en, 0); end

    // rdy_in stall
    put(10, 3, 1, 21, 0, 0, 0, 5); tick();
    put(11, 6, 0, 0, 7, 0, 0, 8); tick();
    idle(); tick();
    chk("stall_pre_en", calc_en, 1);
    chk("stall_pre_rob", calc_rob, 11);
    rdy_in = 0; bcast(21, 'h55);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_cnt", count, 1);
      chk("stall_en", calc_en, 1);
      chk("stall_rob", calc_rob, 11);
    end
    idle(); tick();
    chk("stall_nowake_en", calc_en, 0);
    bcast(21, 'h55); tick();
    idle(); tick();
    chk("stall_wake_rob", calc_rob, 10);
    chk("stall_wake_v1", calc_v1, 'h55);

    // reset between edges
    for (int k = 0; k < 5; k++) begin put(k, 1, 1, 22, 0, 0, 0, 0); tick(); end
    idle();
    chk("rstm_pre_cnt", count, 5);
    rst_in = 1; #1;
    chk("rstm_cnt", count, 0);
    chk("rstm_en", calc_en, 0);
    chk("rstm_op", calc_op, 0);
    chk("rstm_v1", calc_v1, 0);
    chk("rstm_v2", calc_v2, 0);
    chk("rstm_rob", calc_rob, 0);
    chk("rstm_err", err_overflow, 0);
    #1 rst_in = 0;
    tick();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_rob    = TAG_W'($urandom);
      in_op     = OP_W'($urandom);
      in_p1     = ($urandom_range(0, 2) == 0);
      in_p2     = ($urandom_range(0, 2) == 0);
      in_q1     = TAG_W'($urandom_range(0, 3));
      in_q2     = TAG_W'($urandom_range(0, 3));
      in_v1     = $urandom;
      in_v2     = $urandom;
      cdb_valid = ($urandom_range(0, 2) != 0);
      cdb_tag   = TAG_W'($urandom_range(0, 3));
      cdb_val   = $urandom;
      tick();
    end
    idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
